alu_shift_seq: RTL and testbench

- Multi-cycle barrel-shift sequencer. It acts as the initiator on the ALU interface: it drives opcode, in1, in2, carry and oe, and consumes out and flags.
- The ALU can only shift by 1 bit per operation. This block turns a shift-by-N request into N back-to-back 1-bit ALU shift operations.
- It accumulates the result and latches the flags from the final step.
- It sits between the decode/control path and the 32-bit ALU.

---
 rtl/alu_shift_seq_if.sv | 34 +++
 rtl/alu_shift_seq.sv | 164 ++++++++++++++++
 tb/tb_alu_shift_seq.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_shift_seq_if.sv
// Bus between the shift sequencer (master) and the 1-bit-shift ALU (slave).
// The sequencer drives operands and opcode and samples the ALU result and flags.
interface alu_shift_seq_if #(
    parameter int width       = 32,
    parameter int flags_width = 5
);
    logic                   alu_oe;
    logic [3:0]             alu_opcode;
    logic [width-1:0]       alu_in1;
    logic [width-1:0]       alu_in2;
    logic                   alu_carry;
    logic [width-1:0]       alu_out;
    logic [flags_width-1:0] alu_flags;

    modport master (
        output alu_oe,
        output alu_opcode,
        output alu_in1,
        output alu_in2,
        output alu_carry,
        input  alu_out,
        input  alu_flags
    );

    modport slave (
        input  alu_oe,
        input  alu_opcode,
        input  alu_in1,
        input  alu_in2,
        input  alu_carry,
        output alu_out,
        output alu_flags
    );
endinterface

// File: rtl/alu_shift_seq.sv
// Multi-cycle barrel-shift sequencer: turns a shift-by-N request into N
// back-to-back 1-bit ALU shifts, accumulating the value and final-step flags.
module alu_shift_seq #(
    parameter int width       = 32,
    parameter int flags_width = 5,
    parameter int cnt_width   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [width-1:0]       data,
    input  logic [cnt_width-1:0]   amount,
    output logic                   busy,
    output logic                   done,
    output logic [width-1:0]       result,
    output logic [flags_width-1:0] flags,
    alu_shift_seq_if.master        alu
);

    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_shift = 2'd1;
    localparam logic [1:0] st_done  = 2'd2;

    localparam logic [3:0] opc_shl = 4'd7;
    localparam logic [3:0] opc_shr = 4'd8;
    localparam logic [3:0] opc_sar = 4'd9;

    localparam logic [cnt_width-1:0] cnt_zero = {cnt_width{1'b0}};
    localparam logic [cnt_width-1:0] cnt_one  = {{(cnt_width-1){1'b0}}, 1'b1};

    function automatic logic parity_even(input logic [width-1:0] v);
        return ~^v;
    endfunction

    function automatic logic [3:0] opcode_of(input logic [1:0] o);
        logic [3:0] r;
        case (o)
            2'd0:    r = opc_shl;
            2'd1:    r = opc_shr;
            2'd2:    r = opc_sar;
            default: r = opc_shl;
        endcase
        return r;
    endfunction

    // Flags for a request that completes without touching the ALU: {P,S,Z,O,C}.
    function automatic logic [flags_width-1:0] bypass_flags(input logic [width-1:0] v);
        logic [flags_width-1:0] f;
        f    = {flags_width{1'b0}};
        f[4] = parity_even(v);
        f[3] = v[width-1];
        f[2] = (v == {width{1'b0}});
        return f;
    endfunction

    logic [1:0]             state_r;
    logic [1:0]             state_s;
    logic [width-1:0]       acc_r;
    logic [cnt_width-1:0]   cnt_r;
    logic [width-1:0]       result_r;
    logic [flags_width-1:0] flags_r;
    logic [3:0]             opcode_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   oe_r;
    logic                   bypass_s;
    logic                   last_s;

    assign bypass_s = (amount == cnt_zero) || (op == 2'd3);
    assign last_s   = (cnt_r == cnt_one);

    // Next-state decode for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            st_idle: begin
                if (start) begin
                    if (bypass_s) begin
                        state_s = st_done;
                    end else begin
                        state_s = st_shift;
                    end
                end else begin
                    state_s = st_idle;
                end
            end
            st_shift: begin
                if (last_s) begin
                    state_s = st_done;
                end else begin
                    state_s = st_shift;
                end
            end
            st_done: state_s = st_idle;
            default: state_s = st_idle;
        endcase
    end

    // State register with status outputs registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= st_idle;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            oe_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != st_idle);
            done_r  <= (state_s == st_done);
            oe_r    <= (state_s == st_shift);
        end
    end

    // Accumulator, step counter, latched opcode and the held result/flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r    <= {width{1'b0}};
            cnt_r    <= cnt_zero;
            result_r <= {width{1'b0}};
            flags_r  <= {flags_width{1'b0}};
            opcode_r <= opc_shl;
        end else begin
            case (state_r)
                st_idle: begin
                    if (start) begin
                        acc_r    <= data;
                        cnt_r    <= amount;
                        opcode_r <= opcode_of(op);
                        if (bypass_s) begin
                            result_r <= data;
                            flags_r  <= bypass_flags(data);
                        end
                    end
                end
                st_shift: begin
                    acc_r   <= alu.alu_out;
                    flags_r <= alu.alu_flags;
                    // Counter stops at zero so a stray extra step can never wrap it.
                    if (cnt_r != cnt_zero) begin
                        cnt_r <= cnt_r - cnt_one;
                    end
                    if (last_s) begin
                        result_r <= alu.alu_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign flags  = flags_r;

    assign alu.alu_oe     = oe_r;
    assign alu.alu_opcode = opcode_r;
    assign alu.alu_in1    = acc_r;
    assign alu.alu_in2    = {width{1'b0}};
    assign alu.alu_carry  = 1'b0;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Directed bench for alu_shift_seq with a behavioural 1-bit-shift ALU attached.
module tb_alu_shift_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  amount;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  flags;

    int errors;
    int checks;

    alu_shift_seq_if #(.width(32), .flags_width(5)) bus ();

    alu_shift_seq #(.width(32), .flags_width(5), .cnt_width(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .data   (data),
        .amount (amount),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flags  (flags),
        .alu    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: one-bit shifts, flags {P,S,Z,O,C}; junk when not enabled.
    logic [31:0] m_out;
    logic        m_c;
    logic        m_o;
    always_comb begin
        m_out = 32'hDEAD_BEEF;
        m_c   = 1'b0;
        m_o   = 1'b0;
        if (bus.alu_oe) begin
            case (bus.alu_opcode)
                4'd7: begin
                    m_out = bus.alu_in1 << 1;
                    m_c   = bus.alu_in1[31];
                    m_o   = m_out[31] ^ m_c;
                end
                4'd8: begin
                    m_out = bus.alu_in1 >> 1;
                    m_c   = bus.alu_in1[0];
                    m_o   = bus.alu_in1[31];
                end
                4'd9: begin
                    m_out = {bus.alu_in1[31], bus.alu_in1[31:1]};
                    m_c   = bus.alu_in1[0];
                    m_o   = 1'b0;
                end
                default: m_out = 32'h0BAD_0BAD;
            endcase
        end
        bus.alu_out   = m_out;
        bus.alu_flags = {~^m_out, m_out[31], (m_out == 32'd0), m_o, m_c};
    end

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  amount;
        logic [31:0] exp_result;
        logic [4:0]  exp_flags;
        int          exp_lat;
        int          exp_oe;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one request, scramble the inputs after acceptance, then track it to done.
    task automatic run_vec(input vec_t v);
        int lat;
        int oe_cnt;
        int busy_lo;
        int side_bad;
        start  = 1'b1;
        op     = v.op;
        data   = v.data;
        amount = v.amount;
        @(posedge clk);
        #1;
        start  = 1'b0;
        data   = ~v.data;
        amount = ~v.amount;
        op     = ~v.op;
        lat = 0; oe_cnt = 0; busy_lo = 0; side_bad = 0;
        while (!done && lat < 64) begin
            if (bus.alu_oe) oe_cnt++;
            if (!busy) busy_lo++;
            if (bus.alu_in2 !== 32'd0 || bus.alu_carry !== 1'b0) side_bad++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({v.name, " latency"}, lat, v.exp_lat);
        chk({v.name, " result"}, result, v.exp_result);
        chk({v.name, " flags"}, {27'd0, flags}, {27'd0, v.exp_flags});
        chk({v.name, " oe_cycles"}, oe_cnt, v.exp_oe);
        chk({v.name, " busy_low_cycles"}, busy_lo, 32'd0);
        chk({v.name, " busy_at_done"}, {31'd0, busy}, 32'd1);
        chk({v.name, " in2_carry_nonzero"}, side_bad, 32'd0);
        @(posedge clk);
        #1;
        chk({v.name, " done_one_cycle"}, {31'd0, done}, 32'd0);
        chk({v.name, " idle_after"}, {31'd0, busy}, 32'd0);
        chk({v.name, " result_held"}, result, v.exp_result);
    endtask

    initial begin
        int lat;
        int done_seen;
        errors = 0;
        checks = 0;
        vecs[0] = '{"shl1x4",   2'd0, 32'h0000_0001, 5'd4,  32'h0000_0010, 5'b00000, 4,  4};
        vecs[1] = '{"sar31",    2'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 5'b11000, 31, 31};
        vecs[2] = '{"shr1",     2'd1, 32'h8000_0001, 5'd1,  32'h4000_0000, 5'b00011, 1,  1};
        vecs[3] = '{"shl_out",  2'd0, 32'h8000_0000, 5'd1,  32'h0000_0000, 5'b10111, 1,  1};
        vecs[4] = '{"amount0",  2'd0, 32'h0000_0003, 5'd0,  32'h0000_0003, 5'b10000, 0,  0};
        vecs[5] = '{"pass",     2'd3, 32'h8000_0000, 5'd7,  32'h8000_0000, 5'b01000, 0,  0};
        vecs[6] = '{"shr28",    2'd1, 32'hF000_0000, 5'd28, 32'h0000_000F, 5'b10000, 28, 28};
        vecs[7] = '{"shl_ffff", 2'd0, 32'h0000_FFFF, 5'd20, 32'hFFF0_0000, 5'b11001, 20, 20};

        rst = 1'b1; start = 1'b0; op = 2'd0; data = 32'd0; amount = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset flags", {27'd0, flags}, 32'd0);
        chk("reset oe", {31'd0, bus.alu_oe}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Start pulses during SHIFT and during DONE must both be dropped.
        start = 1'b1; op = 2'd0; data = 32'h0000_0001; amount = 5'd20;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; op = 2'd1; data = 32'h0000_FFFF; amount = 5'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 4;
        while (!done && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("ignore latency", lat, 32'd20);
        chk("ignore result", result, 32'h0010_0000);
        chk("ignore flags", {27'd0, flags}, 32'd0);
        start = 1'b1; op = 2'd0; data = 32'h0000_0005; amount = 5'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start in done dropped busy", {31'd0, busy}, 32'd0);
        chk("start in done dropped done", {31'd0, done}, 32'd0);
        chk("start in done result kept", result, 32'h0010_0000);

        // Asynchronous reset in the middle of a shift aborts it silently.
        start = 1'b1; op = 2'd0; data = 32'h0000_0003; amount = 5'd20;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort result", result, 32'd0);
        chk("abort flags", {27'd0, flags}, 32'd0);
        chk("abort oe", {31'd0, bus.alu_oe}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        chk("abort no done", done_seen, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
